mem_sys: RTL and testbench
==========================

# mem_sys

Memory subsystem directly downstream of the core top level. It serves the core's instruction-fetch port and data-access port from one shared word RAM, and decodes a second address region onto a memory-mapped timer that can raise an interrupt. Reads are combinational, so the core sees data in the same cycle. Writes and all timer state are synchronous.

## Interface
Parameters:
- RAM_DEPTH, 4096: RAM size in 32-bit words; power of two.
- RAM_BASE, 32'h0000_0000: RAM region base.
- TMR_BASE, 32'h1000_0000: timer region base; 16-byte window.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ex_addr_i  in  32  data byte address
- ex_data_i  in  32  write data
- ex_req_i  in  1  data access request
- ex_we_i  in  1  write enable; qualified by ex_req_i
- ex_data_o  out  32  read data, combinational
- pc_addr_i  in  32  fetch byte address
- pc_data_o  out  32  instruction word, combinational
- timer_irq_o  out  1  timer interrupt, registered

## Operation
- Accesses are word only. addr[1:0] is ignored. RAM index = (addr − RAM_BASE) >> 2, taking log2(RAM_DEPTH) bits.
- Region decode:
  - RAM hit when addr is in [RAM_BASE, RAM_BASE + 4·RAM_DEPTH).
  - Timer hit when addr is in [TMR_BASE, TMR_BASE + 16).
  - Any other address is unmapped.
- Data read (ex_req_i = 1, ex_we_i = 0):
  - RAM hit returns the RAM word.
  - Timer hit returns the selected register.
  - Unmapped returns 0.
  - ex_data_o = 0 whenever ex_req_i = 0.
- Data write (ex_req_i = 1, ex_we_i = 1): updates the RAM word or the timer register on the rising edge. A write to an unmapped address is dropped silently.
- Fetch port:
  - Always active. Reads RAM only.
  - A pc_addr_i outside the RAM region returns 32'h0000_0013 (NOP).
- Same-cycle write and fetch to the same word: pc_data_o returns the old value. There is no bypass.
- Timer registers (offset from TMR_BASE):
  - 0x0 CTRL: bit0 EN, bit1 IE, bit2 PEND. PEND is write-1-to-clear. Other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 CMP: read/write.
  - 0xC: reads 0, writes ignored.
- Timer behaviour:
  - When EN = 1, COUNT increments each cycle.
  - When EN = 1 and COUNT == CMP, COUNT becomes 0 on the next edge and PEND is set.
  - COUNT wraps 32'hFFFF_FFFF → 0 without setting PEND, unless CMP matches.
- Priority when events coincide in one cycle:
  - A software write to COUNT overrides both increment and match-reset.
  - PEND set by a match wins over a simultaneous W1C.
  - A write to CTRL takes effect from the next cycle; a match in the write cycle still uses the old EN.
- timer_irq_o is a flop holding PEND & IE. It updates on every edge.

## Timing
- Read latency is 0 cycles, for both ports.
- Write latency is 1 edge. Data is visible to reads in the following cycle.
- PEND rises on the edge after the cycle in which COUNT == CMP. timer_irq_o rises one edge after that.
- Reset (rst low, asynchronous):
  - CTRL, COUNT, CMP, PEND and timer_irq_o go to 0.
  - ex_data_o is forced to 0 and pc_data_o is forced to NOP while rst is low.
  - RAM contents are not reset.
- Reset asserted mid-operation aborts any write in that cycle.
- There is no handshake: the core holds req/we for exactly the access cycle, and every access completes in that cycle. There are no stalls.

## Configuration
- MEM_SYS_TIMER_EN defined: the timer is instantiated as described above.
- MEM_SYS_TIMER_EN undefined:
  - No timer logic is built.
  - The timer region decodes as unmapped: reads return 0 and writes are dropped.
  - timer_irq_o is tied to 0.

## Structure
- Shared package holds:
  - Address-map constants: RAM_BASE and TMR_BASE defaults.
  - Timer register offsets.
  - CTRL bit positions.
  - The NOP encoding.
- Sub-module mem_timer contains the timer register file, counter, match logic and IRQ flop.
- The top level holds:
  - The RAM array.
  - Region decode.
  - The read mux.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, then read ex_addr = 0x0000_0013 → returns 0xDEADBEEF. Fetch pc_addr = 0x10 → also returns 0xDEADBEEF.
- Read at 0x2000_0000 → ex_data_o = 0. Fetch at 0x2000_0000 → pc_data_o = 0x0000_0013. A write there leaves the RAM unchanged.
- Program CMP = 3, then CTRL = 0x3:
  - COUNT runs 0,1,2,3,0.
  - PEND is set on the edge where COUNT returns to 0.
  - timer_irq_o goes high one cycle later.
  - Write CTRL = 0x7 → PEND and IRQ clear.
- W1C of PEND issued in the same cycle as a match → PEND stays 1. A COUNT write of 100 in a match cycle → COUNT = 100.
- Drop rst mid-count with PEND = 1 → all timer registers and timer_irq_o read 0 immediately. RAM data written before reset survives.
- Build without MEM_SYS_TIMER_EN → read at TMR_BASE + 4 returns 0, and timer_irq_o stays 0 after a CTRL write.

Source files
------------

// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory subsystem: address map defaults,
// timer register map, CTRL bit positions and the fetch NOP encoding.
package mem_sys_pkg;

  localparam logic [31:0] DEF_RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_TMR_BASE = 32'h1000_0000;
  localparam logic [31:0] TMR_WINDOW   = 32'd16;

  // Timer registers, selected by byte offset [3:2] within the timer window
  typedef enum logic [1:0] {
    TMR_CTRL  = 2'd0,
    TMR_COUNT = 2'd1,
    TMR_CMP   = 2'd2,
    TMR_RSVD  = 2'd3
  } tmr_reg_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_IE_BIT   = 1;
  localparam int CTRL_PEND_BIT = 2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_timer.sv
// Memory-mapped timer: CTRL/COUNT/CMP registers, free-running counter with
// compare-match reset, sticky PEND flag and a registered interrupt output.
module mem_timer
  import mem_sys_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  tmr_reg_e    reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic        en, ie, pend;
  logic [31:0] count, cmp;
  logic        match;
  logic        wr_ctrl, wr_count, wr_cmp;

  assign wr_ctrl  = wr_en && (reg_sel == TMR_CTRL);
  assign wr_count = wr_en && (reg_sel == TMR_COUNT);
  assign wr_cmp   = wr_en && (reg_sel == TMR_CMP);

  // Match uses the EN/CMP values of this cycle; a CTRL or CMP write lands next cycle
  assign match = en && (count == cmp);

  // CTRL bits: EN/IE from software, PEND set by match (wins over W1C)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en   <= 1'b0;
      ie   <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en <= wdata[CTRL_EN_BIT];
        ie <= wdata[CTRL_IE_BIT];
      end
      if (match)
        pend <= 1'b1;
      else if (wr_ctrl && wdata[CTRL_PEND_BIT])
        pend <= 1'b0;
    end
  end

  // Counter: software write beats both increment and match-reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      cmp   <= '0;
    end else begin
      if (wr_count)
        count <= wdata;
      else if (en)
        count <= match ? 32'd0 : count + 32'd1;
      if (wr_cmp)
        cmp <= wdata;
    end
  end

  // Interrupt flop follows PEND & IE with one edge of delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= pend & ie;
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (reg_sel)
      TMR_CTRL: begin
        rdata[CTRL_EN_BIT]   = en;
        rdata[CTRL_IE_BIT]   = ie;
        rdata[CTRL_PEND_BIT] = pend;
      end
      TMR_COUNT: rdata = count;
      TMR_CMP:   rdata = cmp;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_sys.sv
// Memory subsystem top: shared word RAM serving the fetch and data ports with
// combinational reads, plus region decode onto the optional timer.
// Define MEM_SYS_TIMER_EN to build the timer; otherwise its window is unmapped
// and timer_irq_o is tied low.
module mem_sys
  import mem_sys_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 4096,
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] TMR_BASE  = DEF_TMR_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_data_i,
  input  logic        ex_req_i,
  input  logic        ex_we_i,
  output logic [31:0] ex_data_o,
  input  logic [31:0] pc_addr_i,
  output logic [31:0] pc_data_o,
  output logic        timer_irq_o
);

  localparam int          IDX_W     = $clog2(RAM_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_DEPTH) << 2;

  logic [31:0] ram [RAM_DEPTH];

  logic [31:0]      ex_off, pc_off;
  logic             ex_ram_hit, pc_ram_hit;
  logic [IDX_W-1:0] ex_idx, pc_idx;
  logic [31:0]      tmr_rdata;

  // Offset compare is done at 33 bits so a RAM region reaching 4 GiB still decodes
  assign ex_off     = ex_addr_i - RAM_BASE;
  assign pc_off     = pc_addr_i - RAM_BASE;
  assign ex_ram_hit = (ex_addr_i >= RAM_BASE) && ({1'b0, ex_off} < RAM_BYTES);
  assign pc_ram_hit = (pc_addr_i >= RAM_BASE) && ({1'b0, pc_off} < RAM_BYTES);
  assign ex_idx     = ex_off[IDX_W+1:2];
  assign pc_idx     = pc_off[IDX_W+1:2];

`ifdef MEM_SYS_TIMER_EN
  logic [31:0] tmr_off;
  logic        ex_tmr_hit;

  assign tmr_off    = ex_addr_i - TMR_BASE;
  assign ex_tmr_hit = (ex_addr_i >= TMR_BASE) && (tmr_off < TMR_WINDOW);

  mem_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ex_req_i && ex_we_i && ex_tmr_hit),
    .reg_sel (tmr_reg_e'(tmr_off[3:2])),
    .wdata   (ex_data_i),
    .rdata   (tmr_rdata),
    .irq     (timer_irq_o)
  );
`else
  assign tmr_rdata   = '0;
  assign timer_irq_o = 1'b0;
`endif

  // RAM write; sampling rst here drops a write caught by a reset edge
  always_ff @(posedge clk) begin
    if (rst && ex_req_i && ex_we_i && ex_ram_hit)
      ram[ex_idx] <= ex_data_i;
  end

  // Data read mux; unmapped, idle and write cycles return 0
  always_comb begin
    ex_data_o = '0;
    if (rst && ex_req_i && !ex_we_i) begin
      if (ex_ram_hit)
        ex_data_o = ram[ex_idx];
`ifdef MEM_SYS_TIMER_EN
      else if (ex_tmr_hit)
        ex_data_o = tmr_rdata;
`else
      else
        ex_data_o = tmr_rdata;
`endif
    end
  end

  // Fetch read; anything outside RAM (or reset) yields a NOP
  always_comb begin
    pc_data_o = NOP_INSN;
    if (rst && pc_ram_hit)
      pc_data_o = ram[pc_idx];
  end

endmodule

// File: tb/tb_mem_sys.sv
module tb_mem_sys;

  localparam longint RB    = 64'h0000_0000;
  localparam longint TB    = 64'h1000_0000;
  localparam longint DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ex_addr_i = '0, ex_data_i = '0, pc_addr_i = '0;
  logic        ex_req_i = 1'b0, ex_we_i = 1'b0;
  logic [31:0] ex_data_o, pc_data_o;
  logic        timer_irq_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_sys dut (
    .clk         (clk),
    .rst         (rst),
    .ex_addr_i   (ex_addr_i),
    .ex_data_i   (ex_data_i),
    .ex_req_i    (ex_req_i),
    .ex_we_i     (ex_we_i),
    .ex_data_o   (ex_data_o),
    .pc_addr_i   (pc_addr_i),
    .pc_data_o   (pc_data_o),
    .timer_irq_o (timer_irq_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ram_m [longint];
  logic [31:0] m_count = '0, m_cmp = '0;
  bit          m_en = 0, m_ie = 0, m_pend = 0, m_irq = 0;
  logic [31:0] last_ex, last_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_ram_hit(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= RB) && (la - RB < 4 * DEPTH);
  endfunction

  function automatic longint m_idx(input logic [31:0] a);
    return (longint'(a) - RB) / 4;
  endfunction

  function automatic bit m_tmr_hit(input logic [31:0] a);
    longint la = longint'(a);
`ifdef MEM_SYS_TIMER_EN
    return (la >= TB) && (la - TB < 16);
`else
    return la < 0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_ram_hit(a))
      return ram_m.exists(m_idx(a)) ? ram_m[m_idx(a)] : 32'hxxxx_xxxx;
    if (m_tmr_hit(a)) begin
      case ((longint'(a) - TB) / 4)
        0: return {29'd0, m_pend, m_ie, m_en};
        1: return m_count;
        2: return m_cmp;
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    if (m_ram_hit(a)) return ram_m[m_idx(a)];
    return 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_count = 0; m_cmp = 0; m_en = 0; m_ie = 0; m_pend = 0; m_irq = 0;
  endtask

  task automatic model_edge(input bit req, input bit we, input logic [31:0] a,
                            input logic [31:0] d);
    bit match, wc, wcnt, wcmp, nirq;
    longint off;
    if (req && we && m_ram_hit(a)) ram_m[m_idx(a)] = d;
    off   = (longint'(a) - TB) / 4;
    wc    = req && we && m_tmr_hit(a) && off == 0;
    wcnt  = req && we && m_tmr_hit(a) && off == 1;
    wcmp  = req && we && m_tmr_hit(a) && off == 2;
    match = m_en && (m_count == m_cmp);
    nirq  = m_pend && m_ie;
    if (wcnt)      m_count = d;
    else if (m_en) m_count = match ? 32'd0 : m_count + 32'd1;
    if (match)             m_pend = 1;
    else if (wc && d[2])   m_pend = 0;
    if (wc) begin m_en = d[0]; m_ie = d[1]; end
    if (wcmp) m_cmp = d;
    m_irq = nirq;
  endtask

  // One access cycle: drive at negedge, check combinational outputs, advance model at posedge
  task automatic do_cycle(input bit req, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] pc);
    @(negedge clk);
    ex_req_i = req; ex_we_i = we; ex_addr_i = a; ex_data_i = d; pc_addr_i = pc;
    #1;
    if (req && !we) chk("ex_read", ex_data_o, m_read(a));
    else if (!req)  chk("ex_idle", ex_data_o, 32'd0);
    chk("fetch", pc_data_o, m_fetch(pc));
    chk("irq", {31'd0, timer_irq_o}, {31'd0, m_irq});
    last_ex = ex_data_o;
    last_pc = pc_data_o;
    @(posedge clk);
    model_edge(req, we, a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    do_cycle(1, 1, a, d, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    do_cycle(1, 0, a, 32'h0, 32'h0);
  endtask

  logic [31:0] pool [8] = '{32'h0, 32'h10, 32'h44, 32'h100, 32'h1234, 32'h2000, 32'h3FF8, 32'h3FFC};
  logic [31:0] unm  [5] = '{32'h4000, 32'h2000_0000, 32'h0FFF_FFFC, 32'h1000_0010, 32'hFFFF_FFFC};

  initial begin
    logic [31:0] tb32;
    int guard;
    tb32 = TB[31:0];

    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_irq", {31'd0, timer_irq_o}, 32'd0);
    chk("reset_ex", ex_data_o, 32'd0);

    foreach (pool[i]) wr(pool[i], $urandom);

    // Word write / unaligned read / fetch of the same word
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h13);
    chk("rd_unaligned", last_ex, 32'hDEADBEEF);
    do_cycle(0, 0, 0, 0, 32'h10);
    chk("fetch_word", last_pc, 32'hDEADBEEF);

    // Same-cycle write and fetch of one word returns old contents
    do_cycle(1, 1, 32'h44, 32'hA5A5_0001, 32'h44);
    do_cycle(0, 0, 0, 0, 32'h44);
    chk("fetch_after_wr", last_pc, 32'hA5A5_0001);

    // Unmapped region, including an address that would alias RAM word 0
    wr(32'h0, 32'h1111_2222);
    rd(32'h2000_0000);
    chk("unmapped_rd", last_ex, 32'd0);
    do_cycle(0, 0, 0, 0, 32'h2000_0000);
    chk("unmapped_fetch", last_pc, 32'h0000_0013);
    wr(32'h2000_0000, 32'hBAD0_BAD0);
    wr(32'h4000, 32'hBAD1_BAD1);
    rd(32'h0);
    chk("unmapped_wr_drop", last_ex, 32'h1111_2222);

`ifdef MEM_SYS_TIMER_EN
    wr(tb32 + 8, 32'd3);
    wr(tb32, 32'h3);
    rd(tb32 + 4); chk("cnt0", last_ex, 32'd0);
    rd(tb32 + 4); chk("cnt1", last_ex, 32'd1);
    rd(tb32 + 4); chk("cnt2", last_ex, 32'd2);
    rd(tb32 + 4); chk("cnt3", last_ex, 32'd3);
    rd(tb32 + 4); chk("cnt_wrap0", last_ex, 32'd0);
    chk("irq_lag", {31'd0, timer_irq_o}, 32'd0);
    rd(tb32);     chk("ctrl_pend", last_ex, 32'h7);
    chk("irq_set", {31'd0, timer_irq_o}, 32'd1);
    wr(tb32, 32'h7);
    rd(tb32);     chk("ctrl_w1c", last_ex, 32'h3);
    rd(tb32 + 4);
    chk("irq_clear", {31'd0, timer_irq_o}, 32'd0);

    // W1C in a match cycle: match wins
    guard = 0;
    while (!(m_en && m_count == m_cmp) && guard < 20) begin rd(tb32 + 4); guard++; end
    chk("match_wait1", guard < 20, 1);
    wr(tb32, 32'h7);
    rd(tb32); chk("w1c_vs_match", last_ex & 32'h4, 32'h4);

    // COUNT write in a match cycle overrides match-reset
    guard = 0;
    while (!(m_en && m_count == m_cmp) && guard < 20) begin rd(tb32 + 4); guard++; end
    chk("match_wait2", guard < 20, 1);
    wr(tb32 + 4, 32'd100);
    rd(tb32 + 4); chk("cnt_override", last_ex, 32'd100);

    // Async reset mid-count with PEND set
    @(negedge clk);
    ex_req_i = 1; ex_we_i = 0; ex_addr_i = tb32 + 4; pc_addr_i = 32'h10;
    rst = 1'b0;
    #1;
    chk("rst_ex", ex_data_o, 32'd0);
    chk("rst_fetch", pc_data_o, 32'h0000_0013);
    chk("rst_irq", {31'd0, timer_irq_o}, 32'd0);
    // write held across a reset edge is aborted
    ex_we_i = 1; ex_addr_i = 32'h10; ex_data_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    ex_req_i = 0; ex_we_i = 0;
    rst = 1'b1;
    model_reset();
    rd(tb32);     chk("rst_ctrl", last_ex, 32'd0);
    rd(tb32 + 4); chk("rst_count", last_ex, 32'd0);
    rd(tb32 + 8); chk("rst_cmp", last_ex, 32'd0);
    rd(32'h10);   chk("ram_survives", last_ex, 32'hDEADBEEF);

    // COUNT wraps without PEND when CMP does not match
    wr(tb32 + 8, 32'd5);
    wr(tb32 + 4, 32'hFFFF_FFFF);
    wr(tb32, 32'h1);
    rd(tb32 + 4); chk("wrap_pre", last_ex, 32'hFFFF_FFFF);
    rd(tb32 + 4); chk("wrap_post", last_ex, 32'd0);
    rd(tb32);     chk("wrap_nopend", last_ex, 32'h1);
`else
    rd(tb32 + 4); chk("notmr_rd", last_ex, 32'd0);
    wr(tb32, 32'h3);
    wr(tb32 + 8, 32'd0);
    repeat (4) rd(tb32);
    chk("notmr_irq", {31'd0, timer_irq_o}, 32'd0);
`endif

    // Randomized mixed traffic against the model
    for (int n = 0; n < 400; n++) begin
      int cat;
      bit req, we;
      logic [31:0] a, d, pc;
      cat = $urandom_range(0, 3);
      req = ($urandom_range(0, 7) != 0);
      we  = $urandom_range(0, 1);
      case (cat)
        0, 1: begin a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)); d = $urandom; end
        2: begin
          a = tb32 + 32'($urandom_range(0, 15));
          d = 32'($urandom_range(0, 12));
          if ((a & 32'hC) == 32'h0 && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 7));
        end
        default: begin a = unm[$urandom_range(0, 4)]; d = $urandom; end
      endcase
      pc = ($urandom_range(0, 3) == 0) ? unm[$urandom_range(0, 4)] : pool[$urandom_range(0, 7)];
      do_cycle(req, we, a, d, pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
